// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the 7:1 LVDS receive word aligner.
package lvds_rx_pkg;

   localparam int unsigned LVDS_BITS = 7;
   localparam logic [LVDS_BITS-1:0] CLK_PATTERN_DEF = 7'b1100011;
   // Last slip position before the slip counter wraps back to zero.
   localparam logic [2:0] SLIP_WRAP = 3'd6;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StSlip,
      StWait,
      StConfirm,
      StLocked
   } state_t;

endpackage

// File: rtl/lvds_rx_pattern_check.sv
// Clock-lane pattern compare with saturating consecutive match/mismatch counters.
module lvds_rx_pattern_check
   import lvds_rx_pkg::*;
#(
   parameter logic [LVDS_BITS-1:0] CLK_PATTERN = CLK_PATTERN_DEF,
   parameter int unsigned MATCH_COUNT = 16,
   parameter int unsigned LOSS_COUNT = 4
) (
   input  logic                 clkin,
   input  logic                 reset,
   input  logic                 clr,
   input  logic [LVDS_BITS-1:0] clk_word,
   output logic                 match,
   output logic                 match_done,
   output logic                 loss_done
);

   localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
   localparam int unsigned LW = $clog2(LOSS_COUNT + 1);
   localparam logic [MW-1:0] MATCH_TC = MW'(MATCH_COUNT);
   localparam logic [LW-1:0] LOSS_TC = LW'(LOSS_COUNT);

   logic [MW-1:0] match_cnt;
   logic [LW-1:0] loss_cnt;

   assign match = (clk_word == CLK_PATTERN);

   // A match clears the mismatch run and vice versa, so both terminals never coincide.
   always_ff @(posedge clkin) begin
      if (reset || clr) begin
         match_cnt <= '0;
         loss_cnt  <= '0;
      end else if (match) begin
         loss_cnt <= '0;
         if (match_cnt != MATCH_TC) begin
            match_cnt <= match_cnt + MW'(1);
         end
      end else begin
         match_cnt <= '0;
         if (loss_cnt != LOSS_TC) begin
            loss_cnt <= loss_cnt + LW'(1);
         end
      end
   end

   assign match_done = (match_cnt == MATCH_TC);
   assign loss_done  = (loss_cnt == LOSS_TC);

endmodule

// File: rtl/lvds_7to1_rx_align.sv
// Word aligner for the 7:1 LVDS receive path: bitslips until the clock lane reads CLK_PATTERN.
// Optional statistics counters are enabled with LVDS_RX_ALIGN_STATS_EN.
module lvds_7to1_rx_align
   import lvds_rx_pkg::*;
#(
   parameter int unsigned          DATA_LANES  = 4,
   parameter logic [LVDS_BITS-1:0] CLK_PATTERN = CLK_PATTERN_DEF,
   parameter int unsigned          SLIP_WAIT   = 4,
   parameter int unsigned          MATCH_COUNT = 16,
   parameter int unsigned          LOSS_COUNT  = 4
) (
   input  logic                            clkin,
   input  logic                            reset,
   input  logic                            pll_lock,
   input  logic [LVDS_BITS-1:0]            clk_word,
   input  logic [LVDS_BITS*DATA_LANES-1:0] data_word,
   output logic                            bitslip,
   output logic                            aligned,
   output logic [LVDS_BITS*DATA_LANES-1:0] data_out,
   output logic                            data_valid,
   output logic [2:0]                      slip_cnt,
`ifdef LVDS_RX_ALIGN_STATS_EN
   output logic [15:0]                     relock_cnt,
   output logic [15:0]                     words_err,
`endif
   output logic                            align_err
);

   localparam int unsigned WW = $clog2(SLIP_WAIT + 1);
   localparam logic [WW-1:0] WAIT_TC = WW'(SLIP_WAIT - 1);

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic          match;
   logic          match_done;
   logic          loss_done;
   logic          cnt_clr;
   logic          enter_slip;

   // Match/loss runs only matter in CHECK, CONFIRM and LOCKED; hold them at zero elsewhere.
   assign cnt_clr = !pll_lock || (state inside {StIdle, StSlip, StWait});

   lvds_rx_pattern_check #(
      .CLK_PATTERN (CLK_PATTERN),
      .MATCH_COUNT (MATCH_COUNT),
      .LOSS_COUNT  (LOSS_COUNT)
   ) u_check (
      .clkin      (clkin),
      .reset      (reset),
      .clr        (cnt_clr),
      .clk_word   (clk_word),
      .match      (match),
      .match_done (match_done),
      .loss_done  (loss_done)
   );

   always_comb begin
      enter_slip = 1'b0;
      if (pll_lock) begin
         unique case (state)
            StCheck:   enter_slip = !match;
            StConfirm: enter_slip = !match_done && !match;
            StLocked:  enter_slip = loss_done;
            default:   enter_slip = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state      <= StIdle;
         wait_cnt   <= '0;
         bitslip    <= 1'b0;
         aligned    <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         slip_cnt   <= '0;
         align_err  <= 1'b0;
      end else begin
         data_out   <= data_word;
         bitslip    <= 1'b0;
         data_valid <= 1'b0;
         if (!pll_lock) begin
            state    <= StIdle;
            wait_cnt <= '0;
            aligned  <= 1'b0;
            slip_cnt <= '0;
         end else if (enter_slip) begin
            // The pulse is high for exactly the one cycle spent in SLIP.
            state   <= StSlip;
            bitslip <= 1'b1;
            aligned <= 1'b0;
            if (slip_cnt == SLIP_WRAP) begin
               slip_cnt  <= '0;
               align_err <= 1'b1;
            end else begin
               slip_cnt <= slip_cnt + 3'd1;
            end
         end else begin
            unique case (state)
               StIdle: begin
                  state    <= StCheck;
                  slip_cnt <= '0;
               end
               StCheck: state <= StConfirm;
               StSlip: begin
                  state    <= StWait;
                  wait_cnt <= '0;
               end
               StWait: begin
                  if (wait_cnt == WAIT_TC) begin
                     state <= StCheck;
                  end else begin
                     wait_cnt <= wait_cnt + WW'(1);
                  end
               end
               StConfirm: begin
                  if (match_done) begin
                     state   <= StLocked;
                     aligned <= 1'b1;
                  end
               end
               // Valid only while staying locked, so it drops with aligned.
               StLocked: data_valid <= 1'b1;
               default:  state <= StIdle;
            endcase
         end
      end
   end

`ifdef LVDS_RX_ALIGN_STATS_EN
   always_ff @(posedge clkin) begin
      if (reset) begin
         relock_cnt <= '0;
         words_err  <= '0;
      end else if (state == StLocked) begin
         if (pll_lock && loss_done && (relock_cnt != 16'hFFFF)) begin
            relock_cnt <= relock_cnt + 16'd1;
         end
         if (!match && (words_err != 16'hFFFF)) begin
            words_err <= words_err + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lvds_7to1_rx_align.sv
// Directed self-checking bench for lvds_7to1_rx_align with a rotating clock-lane model.
module tb_lvds_7to1_rx_align;
   import lvds_rx_pkg::*;

   localparam logic [6:0] PAT = 7'b1100011;

   logic        clkin = 1'b0;
   logic        reset;
   logic        pll_lock;
   logic [6:0]  clk_word;
   logic [27:0] data_word;
   logic        bitslip;
   logic        aligned;
   logic [27:0] data_out;
   logic        data_valid;
   logic [2:0]  slip_cnt;
   logic        align_err;
`ifdef LVDS_RX_ALIGN_STATS_EN
   logic [15:0] relock_cnt;
   logic [15:0] words_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Clock-lane model: the word rotates left once per bitslip pulse.
   logic [6:0] base = 7'h00;
   logic       bad = 1'b0;
   int         slips = 0;
   int         slip_base = 0;
   int         cyc = 0;
   int         last_pulse = -100;
   int         min_gap = 1000;

   lvds_7to1_rx_align dut (
      .clkin      (clkin),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .clk_word   (clk_word),
      .data_word  (data_word),
      .bitslip    (bitslip),
      .aligned    (aligned),
      .data_out   (data_out),
      .data_valid (data_valid),
      .slip_cnt   (slip_cnt),
`ifdef LVDS_RX_ALIGN_STATS_EN
      .relock_cnt (relock_cnt),
      .words_err  (words_err),
`endif
      .align_err  (align_err)
   );

   always #5 clkin = ~clkin;

   function automatic logic [6:0] rotl7(input logic [6:0] w, input int n);
      logic [6:0] r;
      r = w;
      for (int i = 0; i < n; i++) r = {r[5:0], r[6]};
      return r;
   endfunction

   always @(posedge clkin) begin
      cyc <= cyc + 1;
      if (bitslip) begin
         slips <= slips + 1;
         if (cyc - last_pulse < min_gap) min_gap <= cyc - last_pulse;
         last_pulse <= cyc;
      end
   end

   always_comb clk_word = bad ? 7'h00 : rotl7(base, (slips - slip_base) % 7);

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clkin);
         #1;
      end
   endtask

   // Wait for aligned with a cycle budget; an expired budget is a miscompare.
   task automatic wait_aligned(input string tag, input int budget);
      int k;
      k = 0;
      while (!aligned && k < budget) begin
         tick();
         k++;
      end
      check_val(tag, 32'(aligned), 32'd1);
   endtask

   task automatic restart(input logic [6:0] b);
      pll_lock = 1'b0;
      tick();
      base = b;
      bad = 1'b0;
      slip_base = slips;
      pll_lock = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [27:0] dvec [4];
      int          n;
      dvec[0] = 28'h0000001;
      dvec[1] = 28'hFFFFFFF;
      dvec[2] = 28'h5A5A5A5;
      dvec[3] = 28'h1234567;

      // Reset values
      reset = 1'b1;
      pll_lock = 1'b0;
      data_word = 28'hABCDEF1;
      tick(3);
      check_val("rst_bitslip", 32'(bitslip), 32'd0);
      check_val("rst_aligned", 32'(aligned), 32'd0);
      check_val("rst_data_out", 32'(data_out), 32'd0);
      check_val("rst_data_valid", 32'(data_valid), 32'd0);
      check_val("rst_slip_cnt", 32'(slip_cnt), 32'd0);
      check_val("rst_align_err", 32'(align_err), 32'd0);
      reset = 1'b0;
      tick(2);

      // Aligned clock lane: lock after MATCH_COUNT+1 edges
      base = PAT;
      slip_base = slips;
      pll_lock = 1'b1;
      tick(17);
      check_val("t1_not_yet_aligned", 32'(aligned), 32'd0);
      tick();
      check_val("t1_aligned", 32'(aligned), 32'd1);
      check_val("t1_valid_lags", 32'(data_valid), 32'd0);
      tick();
      check_val("t1_valid", 32'(data_valid), 32'd1);
      check_val("t1_no_slips", 32'(slips - slip_base), 32'd0);
      for (int i = 0; i < 4; i++) begin
         data_word = dvec[i];
         tick();
         check_val("t1_data_out", 32'(data_out), 32'(dvec[i]));
      end

      // Misaligned by 3: base rotated left 3 times equals PAT
      restart(7'b0111100);
      wait_aligned("t2_aligned", 200);
      check_val("t2_slips", 32'(slips - slip_base), 32'd3);
      check_val("t2_slip_cnt", 32'(slip_cnt), 32'd3);

      // Unalignable: 7th pulse sets align_err and wraps slip_cnt
      restart(7'h00);
      n = 0;
      for (int k = 0; k < 200 && n < 8; k++) begin
         tick();
         if (bitslip) begin
            n++;
            if (n == 6) begin
               check_val("t3_err_before_wrap", 32'(align_err), 32'd0);
               check_val("t3_slip_cnt6", 32'(slip_cnt), 32'd6);
            end else if (n == 7) begin
               check_val("t3_align_err", 32'(align_err), 32'd1);
               check_val("t3_slip_wrap", 32'(slip_cnt), 32'd0);
            end else if (n == 8) begin
               check_val("t3_err_sticky", 32'(align_err), 32'd1);
               check_val("t3_slip_resume", 32'(slip_cnt), 32'd1);
            end
         end
      end
      check_val("t3_pulses", 32'(n), 32'd8);
      check_val("t3_min_gap_ok", 32'(min_gap >= 5), 32'd1);

      // Loss while locked
      restart(PAT);
      wait_aligned("t4_aligned", 50);
      tick(2);
      bad = 1'b1;
      tick(3);
      bad = 1'b0;
      tick(2);
      check_val("t4_hold_after_3bad", 32'(aligned), 32'd1);
      check_val("t4_valid_after_3bad", 32'(data_valid), 32'd1);
      bad = 1'b1;
      tick(4);
      bad = 1'b0;
      check_val("t4_still_aligned", 32'(aligned), 32'd1);
      tick();
      check_val("t4_aligned_fall", 32'(aligned), 32'd0);
      check_val("t4_valid_fall", 32'(data_valid), 32'd0);
      check_val("t4_bitslip", 32'(bitslip), 32'd1);
      check_val("t4_slip_cnt", 32'(slip_cnt), 32'd1);
`ifdef LVDS_RX_ALIGN_STATS_EN
      check_val("t4_relock_cnt", 32'(relock_cnt), 32'd1);
      check_val("t4_words_err", 32'(words_err), 32'd7);
`endif

      // pll_lock drop during CONFIRM
      restart(PAT);
      tick(6);
      check_val("t5_in_confirm", 32'(dut.state), 32'(StConfirm));
      pll_lock = 1'b0;
      tick();
      check_val("t5_idle", 32'(dut.state), 32'(StIdle));
      check_val("t5_aligned", 32'(aligned), 32'd0);
      check_val("t5_valid", 32'(data_valid), 32'd0);
      check_val("t5_slip_cnt", 32'(slip_cnt), 32'd0);
      check_val("t5_match_cnt", 32'(dut.u_check.match_cnt), 32'd0);

      // pll_lock drop during LOCKED
      restart(PAT);
      wait_aligned("t5_relock", 50);
      tick();
      check_val("t5_locked_valid", 32'(data_valid), 32'd1);
      pll_lock = 1'b0;
      tick();
      check_val("t5l_idle", 32'(dut.state), 32'(StIdle));
      check_val("t5l_aligned", 32'(aligned), 32'd0);
      check_val("t5l_valid", 32'(data_valid), 32'd0);
      check_val("t5l_match_cnt", 32'(dut.u_check.match_cnt), 32'd0);
      check_val("t5l_err_kept", 32'(align_err), 32'd1);

      // Reset one cycle into SLIP
      restart(7'h00);
      tick(2);
      check_val("t6_in_slip", 32'(bitslip), 32'd1);
      reset = 1'b1;
      tick();
      check_val("t6_bitslip", 32'(bitslip), 32'd0);
      check_val("t6_aligned", 32'(aligned), 32'd0);
      check_val("t6_data_out", 32'(data_out), 32'd0);
      check_val("t6_valid", 32'(data_valid), 32'd0);
      check_val("t6_slip_cnt", 32'(slip_cnt), 32'd0);
      check_val("t6_align_err", 32'(align_err), 32'd0);
      check_val("t6_state", 32'(dut.state), 32'(StIdle));
      reset = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lvds_7to1_rx_align.md
# lvds_7to1_rx_align

Word aligner for the 7:1 LVDS receive path. It sits after the per-lane 1:7 deserializers, in the recovered pixel-clock domain. It watches the deserialized clock lane and issues bitslip pulses to all lanes until the clock lane reads the 7'b1100011 pattern, then declares lock. After lock it forwards the aligned data words registered and flagged valid, and it drops lock and re-aligns if the pattern is lost.

## Interface
Parameters:
- DATA_LANES, 4: number of 7-bit data lanes.
- CLK_PATTERN, 7'b1100011: expected clock-lane word when aligned.
- SLIP_WAIT, 4: cycles to wait after a bitslip pulse before re-sampling (≥2).
- MATCH_COUNT, 16: consecutive matching words required to declare lock.
- LOSS_COUNT, 4: consecutive mismatching words while locked that force re-alignment.

Ports:
- clkin  in  1  pixel clock (deserializer parallel clock). Single clock.
- reset  in  1  synchronous, active-high reset.
- pll_lock  in  1  RX PLL lock. Low forces IDLE.
- clk_word  in  7  deserialized clock-lane word.
- data_word  in  7*DATA_LANES  deserialized data lanes; lane n occupies bits [7n+6:7n].
- bitslip  out  1  one-cycle pulse to all deserializers.
- aligned  out  1  lock status.
- data_out  out  7*DATA_LANES  registered data_word.
- data_valid  out  1  data_out qualifier.
- slip_cnt  out  3  bitslips issued in the current alignment attempt (0–6).
- align_err  out  1  sticky; set when 7 slips cannot find the pattern; cleared by reset.

## Operation
- FSM states: IDLE, CHECK, SLIP, WAIT, CONFIRM, LOCKED.
- IDLE: when pll_lock=1, go to CHECK with slip_cnt=0.
- CHECK: if clk_word==CLK_PATTERN, go to CONFIRM with match counter=1. Otherwise go to SLIP.
- SLIP: assert bitslip for exactly one cycle, then go to WAIT.
  - If slip_cnt==6, set align_err and set slip_cnt to 0.
  - Otherwise increment slip_cnt.
- WAIT: count SLIP_WAIT cycles, then go to CHECK. No new bitslip is allowed within SLIP_WAIT+1 cycles of the previous one.
- CONFIRM:
  - A matching word increments the match counter. Reaching MATCH_COUNT goes to LOCKED.
  - Any mismatch clears the counter and goes to SLIP.
- LOCKED: aligned=1.
  - A mismatch increments the loss counter; a match clears it.
  - Reaching LOSS_COUNT goes to SLIP with aligned=0 and slip_cnt retained. Alignment then continues cyclically from the current slip position.
- pll_lock=0 in any state goes to IDLE on the next edge and clears all counters; align_err is kept. This takes priority over every other transition.
- data_out <= data_word every cycle, regardless of state.
- data_valid <= 1 only when the state is LOCKED, taking the state value before the update.

## Timing
- Reset values: bitslip=0, aligned=0, data_out=0, data_valid=0, slip_cnt=0, align_err=0, state=IDLE, all counters 0.
- data_out latency is 1 cycle from data_word.
- aligned rises on the edge that enters LOCKED. data_valid rises one cycle later, so it always qualifies a word sampled while locked.
- aligned and data_valid fall on the edge that leaves LOCKED. data_valid falls on the same edge as aligned.
- From a correctly aligned input with pll_lock high, aligned rises MATCH_COUNT+1 cycles after pll_lock is first sampled high.
- Simultaneous match and loss-counter terminal count cannot occur: a match clears the loss counter.
- Reset asserted mid-alignment: all outputs return to their reset values on the next edge, and any in-flight bitslip is not extended.
- Counter widths: match counter $clog2(MATCH_COUNT+1); loss counter $clog2(LOSS_COUNT+1); wait counter $clog2(SLIP_WAIT+1).

## Configuration
- LVDS_RX_ALIGN_STATS_EN defined:
  - Adds output relock_cnt, 16 bits. It increments each time LOCKED is exited due to loss, saturates at 16'hFFFF, and is cleared by reset.
  - Adds output words_err, 16 bits. It counts mismatching words while LOCKED, saturates, and is cleared by reset.
- LVDS_RX_ALIGN_STATS_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Package lvds_rx_pkg holds:
  - the state enum;
  - LVDS_BITS=7;
  - the default CLK_PATTERN constant;
  - the slip wrap limit 6.
- One sub-module, lvds_rx_pattern_check. It does the registered-free compare of clk_word against CLK_PATTERN and holds the saturating consecutive match and mismatch counters, exposing match_done and loss_done.
- The FSM, bitslip generation and output registers live in the top module.

## Test plan
- Aligned clock lane: clk_word=7'b1100011 constant, pll_lock rises at cycle 10.
  - No bitslip ever.
  - aligned=1 at cycle 27.
  - data_valid=1 at cycle 28.
  - data_out equals data_word delayed by 1 cycle.
- Misaligned by 3: a clock-lane model rotates the word left on each bitslip.
  - Exactly 3 bitslip pulses, spaced ≥SLIP_WAIT+1 cycles apart.
  - slip_cnt=3, then aligned=1.
- Unalignable: clk_word=7'h00.
  - 7 pulses occur, then align_err=1 and stays set.
  - slip_cnt wraps 6→0 and slipping continues.
- Loss while locked:
  - Inject 3 bad words: aligned stays 1.
  - Inject 4 consecutive bad words: aligned falls, a bitslip follows, and relock_cnt=1 when LVDS_RX_ALIGN_STATS_EN is defined.
- pll_lock drop during CONFIRM and during LOCKED: next cycle the state is IDLE, aligned=0, data_valid=0, and counters are cleared.
- Reset asserted one cycle into SLIP: bitslip is low the next cycle and all outputs are at their reset values, including align_err=0.
